// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_pkg
// Purpose  : Shared state encoding and link-word field layout for the
//            master/slave inter-board game link.
// Revision : 1.0
// ============================================================================
package link_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } link_state_e;

  localparam int LINK_WORD_W    = 4;
  localparam int LINK_PLAY_BIT  = 3;
  localparam int LINK_LEVEL_MSB = 2;
  localparam int LINK_LEVEL_LSB = 0;
  localparam int LINK_LEVEL_W   = LINK_LEVEL_MSB - LINK_LEVEL_LSB + 1;

  localparam logic [LINK_LEVEL_W-1:0] LINK_LEVEL_MAX = 3'd7;

  function automatic logic [LINK_WORD_W-1:0] link_pack(
    input logic                    play,
    input logic [LINK_LEVEL_W-1:0] level
  );
    logic [LINK_WORD_W-1:0] w_word;
    w_word                                = '0;
    w_word[LINK_PLAY_BIT]                 = play;
    w_word[LINK_LEVEL_MSB:LINK_LEVEL_LSB] = level;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/link_master_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : link_master_tx_if
// Purpose  : Button inputs and link/status outputs of the master transmitter.
// Revision : 1.0
// ============================================================================
interface link_master_tx_if;

  logic                             btn_start;
  logic                             btn_stop;
  logic                             btn_hit;
  logic [link_pkg::LINK_WORD_W-1:0] data_out;
  logic                             play_led;
  logic [link_pkg::LINK_LEVEL_W-1:0] level;

  modport master (
    input  btn_start,
    input  btn_stop,
    input  btn_hit,
    output data_out,
    output play_led,
    output level
  );

  modport slave (
    output btn_start,
    output btn_stop,
    output btn_hit,
    input  data_out,
    input  play_led,
    input  level
  );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-flop synchronizer, consecutive-cycle debounce and a one-cycle
//            pulse on each accepted press.
// Revision : 1.0
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  btn,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/link_master_tx.sv
`default_nettype none
// ============================================================================
// Module   : link_master_tx
// Purpose  : Master-side game FSM with hold-protected link word output.
//            Define LINK_TX_TIMEOUT_EN to compile in the PLAY inactivity timeout.
// Revision : 1.0
// ============================================================================
module link_master_tx
  import link_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 4,
  parameter int TIMEOUT_SEC     = 60
) (
  input wire               clk,
  input wire               rst,
  link_master_tx_if.master bus
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255 || DEBOUNCE_CYCLES < 1 ||
      CLK_HZ < 1 || TIMEOUT_SEC < 1) begin : g_bad_params
    $error("link_master_tx: parameter out of range");
  end

  logic w_start_pulse;
  logic w_stop_pulse;
  logic w_hit_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_start),
    .pulse (w_start_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_stop),
    .pulse (w_stop_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hit (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_hit),
    .pulse (w_hit_pulse)
  );

  link_state_e             r_state;
  link_state_e             w_state_nxt;
  logic [LINK_LEVEL_W-1:0] r_level;
  logic [LINK_LEVEL_W-1:0] w_level_nxt;
  logic                    w_hit_acc;
  logic                    w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_level <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_hit_acc   = 1'b0;
    case (r_state)
      IDLE: begin
        w_level_nxt = '0;
        if (w_start_pulse) w_state_nxt = PLAY;
      end
      PLAY: begin
        // Stop (or timeout) takes priority over a coincident hit.
        if (w_stop_pulse || w_timeout) begin
          w_state_nxt = IDLE;
          w_level_nxt = '0;
        end else if (w_hit_pulse) begin
          w_hit_acc = 1'b1;
          if (r_level != LINK_LEVEL_MAX) w_level_nxt = r_level + 3'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_level_nxt = '0;
      end
    endcase
  end

`ifdef LINK_TX_TIMEOUT_EN
  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SEC_W  = $clog2(TIMEOUT_SEC + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0]  SEC_LIMIT = SEC_W'(TIMEOUT_SEC);

  logic [TICK_W-1:0] r_tick;
  logic [SEC_W-1:0]  r_sec;

  // Held at zero outside PLAY, so entry into PLAY always starts from a clean count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
      r_sec  <= '0;
    end else if (r_state != PLAY || w_hit_acc) begin
      r_tick <= '0;
      r_sec  <= '0;
    end else if (r_sec != SEC_LIMIT) begin
      if (r_tick == TICK_LAST) begin
        r_tick <= '0;
        r_sec  <= r_sec + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  assign w_timeout = (r_state == PLAY) && (r_sec == SEC_LIMIT);
`else
  assign w_timeout = 1'b0;
`endif

  logic [LINK_WORD_W-1:0] w_next_word;
  logic [LINK_WORD_W-1:0] r_data_out;
  logic [7:0]             r_hold_cnt;

  assign w_next_word = link_pack(r_state == PLAY, r_level);

  // The slave samples without a handshake, so each word is held for HOLD_CYCLES;
  // values produced during the hold are dropped in favour of the latest one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != 8'd0) begin
      r_hold_cnt <= r_hold_cnt - 8'd1;
    end else if (w_next_word != r_data_out) begin
      r_data_out <= w_next_word;
      r_hold_cnt <= HOLD_LOAD;
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.play_led = (r_state == PLAY);
  assign bus.level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_link_master_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_master_tx
// Purpose  : Directed self-checking bench for link_master_tx.
// Revision : 1.0
// ============================================================================
module tb_link_master_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  link_master_tx_if lif ();

  int passed = 0;
  int total  = 0;

  int         neg_cnt  = 0;
  int         last_chg = 0;
  int         gap_viol = 0;
  bit         have_chg = 1'b0;
  logic [3:0] prev_do  = 4'b0000;

  link_master_tx #(
    .CLK_HZ          (10),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (4),
    .TIMEOUT_SEC     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (lif)
  );

  always #5 clk = ~clk;

  // Tracks spacing between link word changes, in clock cycles.
  always @(negedge clk) begin
    neg_cnt = neg_cnt + 1;
    if (rst) begin
      have_chg = 1'b0;
      prev_do  = lif.data_out;
    end else if (lif.data_out !== prev_do) begin
      if (have_chg && (neg_cnt - last_chg) < 4) gap_viol = gap_viol + 1;
      have_chg = 1'b1;
      last_chg = neg_cnt;
      prev_do  = lif.data_out;
    end
  end

  task automatic release_all;
    lif.btn_start = 1'b0;
    lif.btn_stop  = 1'b0;
    lif.btn_hit   = 1'b0;
  endtask

  // Clean press: 10 cycles high, 10 cycles low.
  task automatic press_btn(input bit s, input bit p, input bit h);
    @(negedge clk);
    lif.btn_start = s;
    lif.btn_stop  = p;
    lif.btn_hit   = h;
    repeat (10) @(negedge clk);
    release_all();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    release_all();
    repeat (3) @(negedge clk);
    total++;
    if (lif.data_out !== 4'b0000 || lif.play_led !== 1'b0 || lif.level !== 3'd0)
      $display("FAIL reset_values: data_out=%b play_led=%b level=%0d, expected 0000/0/0",
               lif.data_out, lif.play_led, lif.level);
    else passed++;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lif.data_out !== 4'b0000 || lif.play_led !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL idle_50: %0d bad cycles, expected 0", bad);
    else passed++;
  endtask

  task automatic test_bounce_start;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lif.btn_start = ~lif.btn_start;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    total++;
    if (lif.data_out !== 4'b0000 || lif.play_led !== 1'b0)
      $display("FAIL bounce: data_out=%b play_led=%b, expected 0000/0",
               lif.data_out, lif.play_led);
    else passed++;

    @(negedge clk);
    lif.btn_start = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if (lif.data_out !== 4'b0000)
      $display("FAIL start_not_early: data_out=%b, expected 0000", lif.data_out);
    else passed++;
    total++;
    if (lif.play_led !== 1'b1)
      $display("FAIL start_play_led: play_led=%b, expected 1", lif.play_led);
    else passed++;
    @(negedge clk);
    total++;
    if (lif.data_out !== 4'b1000)
      $display("FAIL start_latency: data_out=%b, expected 1000", lif.data_out);
    else passed++;
    @(negedge clk);
    lif.btn_start = 1'b0;
  endtask

  task automatic test_hits;
    logic [3:0] exp_word;
    int         lv;
    for (int k = 1; k <= 9; k++) begin
      press_btn(1'b0, 1'b0, 1'b1);
      lv       = (k > 7) ? 7 : k;
      exp_word = {1'b1, lv[2:0]};
      total++;
      if (lif.data_out !== exp_word)
        $display("FAIL hit_%0d: data_out=%b, expected %b", k, lif.data_out, exp_word);
      else passed++;
    end
    total++;
    if (lif.level !== 3'd7)
      $display("FAIL hit_saturate_level: level=%0d, expected 7", lif.level);
    else passed++;
  endtask

  task automatic test_stop_vs_hit;
    press_btn(1'b0, 1'b1, 1'b0);
    total++;
    if (lif.data_out !== 4'b0000 || lif.play_led !== 1'b0)
      $display("FAIL stop: data_out=%b play_led=%b, expected 0000/0",
               lif.data_out, lif.play_led);
    else passed++;
    press_btn(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) press_btn(1'b0, 1'b0, 1'b1);
    total++;
    if (lif.data_out !== 4'b1011)
      $display("FAIL level3: data_out=%b, expected 1011", lif.data_out);
    else passed++;
    press_btn(1'b0, 1'b1, 1'b1);
    total++;
    if (lif.data_out !== 4'b0000 || lif.level !== 3'd0 || lif.play_led !== 1'b0)
      $display("FAIL stop_wins: data_out=%b level=%0d play_led=%b, expected 0000/0/0",
               lif.data_out, lif.level, lif.play_led);
    else passed++;
    press_btn(1'b0, 1'b0, 1'b1);
    total++;
    if (lif.data_out !== 4'b0000 || lif.level !== 3'd0)
      $display("FAIL hit_in_idle: data_out=%b level=%0d, expected 0000/0",
               lif.data_out, lif.level);
    else passed++;
  endtask

  task automatic test_hold;
    int saw_skipped;
    saw_skipped = 0;
    @(negedge clk);
    lif.btn_start = 1'b1;
    @(negedge clk);
    lif.btn_hit = 1'b1;
    @(negedge clk);
    lif.btn_stop = 1'b1;
    for (int n = 3; n <= 13; n++) begin
      @(negedge clk);
      if (lif.data_out === 4'b1001) saw_skipped++;
      if (n == 9) begin
        total++;
        if (lif.data_out !== 4'b1000 || lif.level !== 3'd1)
          $display("FAIL hold_first: data_out=%b level=%0d, expected 1000/1",
                   lif.data_out, lif.level);
        else passed++;
      end
      if (n == 10) begin
        total++;
        if (lif.level !== 3'd0 || lif.play_led !== 1'b0)
          $display("FAIL hold_internal_idle: level=%0d play_led=%b, expected 0/0",
                   lif.level, lif.play_led);
        else passed++;
      end
      if (n == 12) begin
        total++;
        if (lif.data_out !== 4'b1000)
          $display("FAIL hold_frozen: data_out=%b, expected 1000", lif.data_out);
        else passed++;
      end
      if (n == 13) begin
        total++;
        if (lif.data_out !== 4'b0000)
          $display("FAIL hold_release: data_out=%b, expected 0000", lif.data_out);
        else passed++;
      end
    end
    release_all();
    repeat (15) @(negedge clk);
    total++;
    if (saw_skipped !== 0)
      $display("FAIL hold_skip: 1001 seen %0d cycles, expected 0", saw_skipped);
    else passed++;
    total++;
    if (gap_viol !== 0)
      $display("FAIL hold_min_gap: %0d short gaps, expected 0", gap_viol);
    else passed++;
  endtask

  task automatic test_async_reset;
    press_btn(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) press_btn(1'b0, 1'b0, 1'b1);
    total++;
    if (lif.data_out !== 4'b1101)
      $display("FAIL level5: data_out=%b, expected 1101", lif.data_out);
    else passed++;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (lif.data_out !== 4'b0000 || lif.play_led !== 1'b0 || lif.level !== 3'd0)
      $display("FAIL async_reset: data_out=%b play_led=%b level=%0d, expected 0000/0/0",
               lif.data_out, lif.play_led, lif.level);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (lif.data_out !== 4'b0000 || lif.play_led !== 1'b0)
      $display("FAIL after_reset: data_out=%b play_led=%b, expected 0000/0",
               lif.data_out, lif.play_led);
    else passed++;
  endtask

  task automatic test_timeout;
    logic [3:0] exp_late;
`ifdef LINK_TX_TIMEOUT_EN
    exp_late = 4'b0000;
`else
    exp_late = 4'b1000;
`endif
    @(negedge clk);
    lif.btn_start = 1'b1;
    repeat (10) @(negedge clk);
    lif.btn_start = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (lif.data_out !== 4'b1000)
      $display("FAIL timeout_play: data_out=%b, expected 1000", lif.data_out);
    else passed++;
    repeat (25) @(negedge clk);
    total++;
    if (lif.data_out !== exp_late)
      $display("FAIL timeout_45: data_out=%b, expected %b", lif.data_out, exp_late);
    else passed++;
    repeat (100) @(negedge clk);
    total++;
    if (lif.data_out !== exp_late)
      $display("FAIL timeout_145: data_out=%b, expected %b", lif.data_out, exp_late);
    else passed++;
  endtask

  initial begin
    release_all();
    test_reset();
    test_bounce_start();
    test_hits();
    test_stop_vs_hit();
    test_hold();
    test_async_reset();
    test_timeout();
    total++;
    if (gap_viol !== 0)
      $display("FAIL min_gap_overall: %0d short gaps, expected 0", gap_viol);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/link_master_tx.md
# link_master_tx

Master-board side of the 4-bit inter-board game link. Debounces the local start/stop/hit buttons and runs the game state machine (idle/play, hit level 0..7). Drives the registered word {play, level[2:0]} onto the board-to-board pins. The slave board samples this word through a 3-flop synchronizer with no handshake, so every word change is held stable for a guaranteed minimum number of cycles.

## Interface
- CLK_HZ, 100_000_000: clock frequency; sets the 1-second tick for the timeout.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles before a button level is accepted.
- HOLD_CYCLES, 4: minimum cycles each transmitted word stays unchanged; legal range 2..255.
- TIMEOUT_SEC, 60: seconds in PLAY without a hit before a forced return to IDLE.

- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- btn_start  in  1  raw start button, asynchronous, active-high.
- btn_stop  in  1  raw stop button, asynchronous, active-high.
- btn_hit  in  1  raw hit button, asynchronous, active-high.
- data_out  out  4  link word: [3] play, [2:0] level; driven directly from flops.
- play_led  out  1  local copy of FSM state (1 = PLAY).
- level  out  3  local copy of the current level, undelayed by the hold logic.

## Operation
- Each button path: 2-flop synchronizer, then debounce. The debounced level flips only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. A 0->1 flip of the debounced level produces a one-cycle pulse.
- FSM states:
  - IDLE: level=0. A start pulse moves to PLAY with level=0.
  - PLAY: a hit pulse increments level, saturating at 7 (a hit at 7 leaves level at 7 and still restarts the timeout). A stop pulse returns to IDLE with level=0.
- Simultaneous pulses in PLAY: stop wins over hit. A start pulse in PLAY is ignored. Stop and hit pulses in IDLE are ignored.
- next_word = {state==PLAY, level}.
- Hold logic:
  - hold_cnt counts down to 0.
  - When hold_cnt==0 and next_word != data_out, data_out <= next_word and hold_cnt <= HOLD_CYCLES-1.
  - While hold_cnt != 0, data_out is frozen. Intermediate next_word values are dropped; the latest value wins once the hold expires.
- Reset at any time: state=IDLE, level=0, data_out=0, hold_cnt=0, debounce counters and debounced levels=0, timeout counters=0.

## Timing
- Reset values: data_out=4'b0000, play_led=0, level=0.
- Button press to pulse: 2 sync cycles plus DEBOUNCE_CYCLES. Pulse to FSM update (play_led/level): 1 cycle.
- FSM update to data_out: 1 cycle if the hold has expired; otherwise up to HOLD_CYCLES cycles.
- Consecutive data_out changes are separated by at least HOLD_CYCLES cycles. data_out never changes more often than this, even under maximum hit rate.
- Timeout:
  - A tick counter wraps every CLK_HZ cycles and drives a seconds counter.
  - Both counters clear on entry to PLAY and on every accepted hit.
  - When the seconds counter reaches TIMEOUT_SEC, the FSM goes to IDLE on the next cycle, with the same effect as a stop pulse.
  - In IDLE, both counters are held at 0.

## Configuration
- LINK_TX_TIMEOUT_EN defined: the timeout counters and forced return to IDLE are compiled in.
- LINK_TX_TIMEOUT_EN undefined: no timeout logic is present; PLAY is left only by stop or reset. TIMEOUT_SEC and CLK_HZ are then unused.

## Structure
- Shared package link_pkg:
  - state enum (IDLE, PLAY);
  - word field constants LINK_PLAY_BIT=3, LINK_LEVEL_MSB=2, LINK_LEVEL_LSB=0;
  - LINK_LEVEL_MAX=7.
- The slave board uses the same package for decoding.
- Sub-module btn_debounce (synchronizer, debounce counter, rising-edge pulse; parameter DEBOUNCE_CYCLES) is instantiated three times.
- The FSM, hold logic and timeout live in the top module.

## Test plan
All scenarios use sim parameters DEBOUNCE_CYCLES=4, HOLD_CYCLES=4, CLK_HZ=10, TIMEOUT_SEC=3.
- Reset then idle: data_out=0, play_led=0 for 50 cycles. Assert rst mid-PLAY at level 5 -> data_out=0 in the same cycle (asynchronous).
- Bounce: btn_start toggled every 2 cycles for 20 cycles -> no pulse, data_out stays 0. Clean press held 10 cycles -> data_out=4'b1000 at 8 cycles after the first sampled high.
- Hits: start, then 9 clean hits spaced 20 cycles apart -> data_out steps 1000, 1001, …, 1111 and stays 1111 after hits 8 and 9.
- Hold: two level changes 1 cycle apart in internal state -> data_out skips the intermediate value, changes exactly 4 cycles after the first change, and no two data_out changes occur less than 4 cycles apart (assertion).
- Stop vs hit: stop and hit pulses in the same cycle at level 3 -> data_out=4'b0000, level=0. A hit pulse in IDLE -> no change.
- Timeout (LINK_TX_TIMEOUT_EN): start with no hits -> data_out=0 after 30 cycles plus pipeline latency. Without the macro -> data_out stays 4'b1000 indefinitely.
